// File: rtl/servo_pwm_decoder.sv
// rtl/servo_pwm_decoder.sv - servo PWM receiver: period/on-time measurement, direction decode, valid/ack
// Define SERVO_PWM_DECODER_FILTER_EN to insert a FILTER_LEN-tick glitch filter after the synchronizer.
module servo_pwm_decoder #(
  parameter int PERIOD_BITS   = 16,
  parameter int DIR_LO_MAX    = 1400,
  parameter int DIR_HI_MIN    = 1600,
  parameter int TIMEOUT_TICKS = 30000
`ifdef SERVO_PWM_DECODER_FILTER_EN
  ,
  parameter int FILTER_LEN    = 3
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic                   pwm_in,
  input  logic                   ack,
  output logic                   valid,
  output logic [PERIOD_BITS-1:0] on_time,
  output logic [PERIOD_BITS-1:0] period,
  output logic [1:0]             dir,
  output logic                   overrun,
  output logic                   timeout
);

  localparam logic [PERIOD_BITS-1:0] CNT_ONE = PERIOD_BITS'(1);
  localparam logic [PERIOD_BITS-1:0] TO_LAST = PERIOD_BITS'(TIMEOUT_TICKS - 1);
  localparam logic [PERIOD_BITS-1:0] LO_MAX  = PERIOD_BITS'(DIR_LO_MAX);
  localparam logic [PERIOD_BITS-1:0] HI_MIN  = PERIOD_BITS'(DIR_HI_MIN);
  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_FWD  = 2'b01;
  localparam logic [1:0] DIR_BWD  = 2'b10;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t                   state, state_nx;
  logic                     sync1, sync2;
  logic                     lvl, lvl_q;
  logic                     rise, fall;
  logic [PERIOD_BITS-1:0]   high_cnt, high_nx;
  logic [PERIOD_BITS-1:0]   per_cnt, per_nx;
  logic [PERIOD_BITS-1:0]   idle_cnt, idle_nx;
  logic                     meas, to_set, to_clr;
  logic [1:0]               dir_dec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      lvl_q <= 1'b0;
    end else if (clk_en) begin
      sync1 <= pwm_in;
      sync2 <= sync1;
      lvl_q <= lvl;
    end
  end

`ifdef SERVO_PWM_DECODER_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN + 1);
  logic           filt;
  logic [FCW-1:0] fcnt;

  // The filtered level follows only after FILTER_LEN consecutive ticks at the new value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt <= 1'b0;
      fcnt <= '0;
    end else if (clk_en) begin
      if (sync2 == filt) begin
        fcnt <= '0;
      end else if (fcnt == FCW'(FILTER_LEN - 1)) begin
        filt <= sync2;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign lvl = filt;
`else
  assign lvl = sync2;
`endif

  assign rise = lvl & ~lvl_q;
  assign fall = ~lvl & lvl_q;

  always_comb begin
    dir_dec = DIR_STOP;
    if (high_cnt <= LO_MAX)
      dir_dec = DIR_FWD;
    else if (high_cnt >= HI_MIN)
      dir_dec = DIR_BWD;
  end

  always_comb begin
    state_nx = state;
    high_nx  = high_cnt;
    per_nx   = per_cnt;
    idle_nx  = idle_cnt;
    meas     = 1'b0;
    to_set   = 1'b0;
    to_clr   = 1'b0;
    if (clk_en) begin
      unique case (state)
        IDLE: begin
          if (rise) begin
            state_nx = HIGH;
            high_nx  = CNT_ONE;
            per_nx   = CNT_ONE;
            idle_nx  = '0;
            to_clr   = 1'b1;
          end else if (!timeout) begin
            // Only the stretch after reset can time out here; afterwards timeout is already set.
            if (idle_cnt == TO_LAST) begin
              to_set  = 1'b1;
              idle_nx = '0;
            end else begin
              idle_nx = idle_cnt + 1'b1;
            end
          end
        end
        HIGH: begin
          if (per_cnt == TO_LAST) begin
            to_set   = 1'b1;
            state_nx = IDLE;
            high_nx  = '0;
            per_nx   = '0;
          end else begin
            per_nx = per_cnt + 1'b1;
            if (fall)
              state_nx = LOW;
            else
              high_nx = high_cnt + 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            meas     = 1'b1;
            state_nx = HIGH;
            high_nx  = CNT_ONE;
            per_nx   = CNT_ONE;
          end else if (per_cnt == TO_LAST) begin
            to_set   = 1'b1;
            state_nx = IDLE;
            high_nx  = '0;
            per_nx   = '0;
          end else begin
            per_nx = per_cnt + 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          high_nx  = '0;
          per_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      high_cnt <= '0;
      per_cnt  <= '0;
      idle_cnt <= '0;
      on_time  <= '0;
      period   <= '0;
      dir      <= DIR_STOP;
      valid    <= 1'b0;
      overrun  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nx;
      high_cnt <= high_nx;
      per_cnt  <= per_nx;
      idle_cnt <= idle_nx;
      if (meas) begin
        on_time <= high_cnt;
        period  <= per_cnt;
        dir     <= dir_dec;
      end
      // ack is honoured every clk cycle; a same-cycle new measurement wins and is not an overrun.
      if (meas)
        valid <= 1'b1;
      else if (ack)
        valid <= 1'b0;
      if (meas && valid && !ack)
        overrun <= 1'b1;
      if (to_set)
        timeout <= 1'b1;
      else if (to_clr)
        timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// tb/tb_servo_pwm_decoder.sv - randomized self-checking bench for servo_pwm_decoder against a waveform-level model
module tb_servo_pwm_decoder;

  localparam int PB  = 8;
  localparam int LO  = 5;
  localparam int HI  = 10;
  localparam int TO  = 50;
  localparam int FLT = 3;
`ifdef SERVO_PWM_DECODER_FILTER_EN
  localparam bit FILT_ON   = 1'b1;
  localparam int LAT_EXTRA = FLT;
`else
  localparam bit FILT_ON   = 1'b0;
  localparam int LAT_EXTRA = 0;
`endif

  typedef struct {
    int p;
    int h;
    int d;
  } meas_t;

  logic          clk = 1'b0;
  logic          reset, clk_en, pwm_in, ack;
  logic          valid, overrun, timeout;
  logic [PB-1:0] on_time, period;
  logic [1:0]    dir;

  int    n_pass = 0;
  int    n_total = 0;
  int    en_div = 1;
  int    cyc = 0;
  bit    auto_ack = 1'b0;
  bit    wave[$];
  meas_t obs_q[$];
  meas_t exp_q[$];

  servo_pwm_decoder #(
    .PERIOD_BITS  (PB),
    .DIR_LO_MAX   (LO),
    .DIR_HI_MIN   (HI),
    .TIMEOUT_TICKS(TO)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .pwm_in (pwm_in),
    .ack    (ack),
    .valid  (valid),
    .on_time(on_time),
    .period (period),
    .dir    (dir),
    .overrun(overrun),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Consumer: records each measurement and acks it for one cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_ack) begin
        ack = 1'b0;
        if (valid) begin
          obs_q.push_back('{int'(period), int'(on_time), int'(dir)});
          ack = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_tick(input bit lvl);
    bit en;
    do begin
      @(negedge clk);
      pwm_in = lvl;
      en = (cyc % en_div) == 0;
      clk_en = en;
      cyc++;
      @(posedge clk);
    end while (!en);
    #1;
  endtask

  task automatic wave_add(input bit lvl, input int n);
    for (int i = 0; i < n; i++) wave.push_back(lvl);
  endtask

  task automatic wave_period(input int h, input int p);
    wave_add(1'b1, h);
    wave_add(1'b0, p - h);
  endtask

  task automatic play();
    for (int i = 0; i < wave.size(); i++) drive_tick(wave[i]);
    for (int i = 0; i < 8; i++) drive_tick(wave[wave.size() - 1]);
  endtask

  function automatic int dir_of(input int h);
    if (h <= LO) return 1;
    if (h >= HI) return 2;
    return 0;
  endfunction

  // Reference: filter the tick waveform, find rising edges, and measure each edge-to-edge span.
  function automatic void build_exp();
    bit f[$];
    int r[$];
    bit cur = 1'b0;
    bit prev_raw = 1'b0;
    bit prev = 1'b0;
    int run = FLT;
    exp_q.delete();
    for (int i = 0; i < wave.size(); i++) begin
      if (FILT_ON) begin
        run = (wave[i] == prev_raw) ? run + 1 : 1;
        prev_raw = wave[i];
        if (run >= FLT) cur = wave[i];
        f.push_back(cur);
      end else begin
        f.push_back(wave[i]);
      end
    end
    for (int i = 0; i < f.size(); i++) begin
      if (f[i] && !prev) r.push_back(i);
      prev = f[i];
    end
    for (int k = 0; k + 1 < r.size(); k++) begin
      int h = 0;
      for (int j = r[k]; j < r[k + 1]; j++) h += int'(f[j]);
      exp_q.push_back('{r[k + 1] - r[k], h, dir_of(h)});
    end
  endfunction

  task automatic compare_obs(input string tag);
    chk($sformatf("%s_count", tag), obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_period%0d", tag, i), obs_q[i].p, exp_q[i].p);
      chk($sformatf("%s_on_time%0d", tag, i), obs_q[i].h, exp_q[i].h);
      chk($sformatf("%s_dir%0d", tag, i), obs_q[i].d, exp_q[i].d);
    end
  endtask

  task automatic do_reset();
    auto_ack = 1'b0;
    reset = 1'b1;
    clk_en = 1'b0;
    pwm_in = 1'b0;
    ack = 1'b0;
    en_div = 1;
    cyc = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    obs_q.delete();
    wave.delete();
  endtask

  initial begin
    int n;
    int hs[$];
    do_reset();
    chk("rst_valid", valid, 0);
    chk("rst_on_time", on_time, 0);
    chk("rst_period", period, 0);
    chk("rst_dir", dir, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout, 0);

    // Directed on-times at period 20, including both decode boundaries.
    do_reset();
    auto_ack = 1'b1;
    wave_add(1'b0, 2);
    hs = '{3, 3, 3, 7, 12, 5, 6, 9, 10};
    foreach (hs[i]) wave_period(hs[i], 20);
    wave_add(1'b1, 3);
    build_exp();
    play();
    compare_obs("dirtab");
    chk("dirtab_overrun", overrun, 0);

    // Latency of the first valid relative to the second rising edge.
    do_reset();
    wave_add(1'b0, 3);
    wave_period(5, 20);
    for (int i = 0; i < wave.size(); i++) drive_tick(wave[i]);
    drive_tick(1'b1);
    n = 0;
    while (!valid && n < 20) begin
      drive_tick(1'b1);
      n++;
    end
    chk("first_valid_lat", n, 2 + LAT_EXTRA);
    chk("first_period", period, 20);
    chk("first_on_time", on_time, 5);
    chk("first_dir", dir, 1);

    // Randomized periods and duty, acked every time.
    for (int round = 0; round < 2; round++) begin
      do_reset();
      auto_ack = 1'b1;
      wave_add(1'b0, 2);
      for (int k = 0; k < 6; k++) begin
        int p = $urandom_range(45, 8);
        wave_period($urandom_range(p - 4, 4), p);
      end
      wave_add(1'b1, 3);
      build_exp();
      play();
      compare_obs($sformatf("rand%0d", round));
    end

    // Never acked over three measurements.
    do_reset();
    wave_add(1'b0, 2);
    wave_period(3, 20);
    wave_period(7, 20);
    wave_period(12, 20);
    wave_add(1'b1, 3);
    build_exp();
    play();
    chk("ovr_valid", valid, 1);
    chk("ovr_overrun", overrun, 1);
    chk("ovr_period", period, exp_q[exp_q.size() - 1].p);
    chk("ovr_on_time", on_time, exp_q[exp_q.size() - 1].h);
    chk("ovr_dir", dir, exp_q[exp_q.size() - 1].d);
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("ovr_ack_valid", valid, 0);
    chk("ovr_sticky", overrun, 1);

    // Timeout in IDLE after reset.
    do_reset();
    for (int i = 0; i < TO - 1; i++) drive_tick(1'b0);
    chk("idle_to_before", timeout, 0);
    drive_tick(1'b0);
    chk("idle_to_at", timeout, 1);

    // Timeout with the input stuck high, then recovery.
    do_reset();
    drive_tick(1'b0);
    drive_tick(1'b0);
    drive_tick(1'b1);
    for (int i = 0; i < TO + LAT_EXTRA; i++) drive_tick(1'b1);
    chk("high_to_before", timeout, 0);
    drive_tick(1'b1);
    chk("high_to_at", timeout, 1);
    chk("high_to_valid", valid, 0);
    auto_ack = 1'b1;
    wave.delete();
    wave_add(1'b0, 5);
    wave_period(6, 16);
    wave_add(1'b1, 3);
    build_exp();
    play();
    compare_obs("to_recover");
    chk("to_cleared", timeout, 0);

    // Sparse clk_en: measurements are in ticks, then asynchronous reset mid-HIGH.
    do_reset();
    en_div = 4;
    wave_add(1'b0, 2);
    for (int k = 0; k < 3; k++) wave_period($urandom_range(16, 4), 20);
    wave_add(1'b1, 3);
    build_exp();
    play();
    chk("en4_period", period, 20);
    chk("en4_on_time", on_time, exp_q[exp_q.size() - 1].h);
    chk("en4_valid", valid, 1);
    chk("en4_overrun", overrun, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_period", period, 0);
    chk("arst_on_time", on_time, 0);
    chk("arst_dir", dir, 0);
    chk("arst_overrun", overrun, 0);
    @(negedge clk);
    reset = 1'b0;

    // Two-tick low glitch inside the high phase.
    do_reset();
    auto_ack = 1'b1;
    wave_add(1'b0, 2);
    for (int k = 0; k < 2; k++) begin
      wave_add(1'b1, 4);
      wave_add(1'b0, 2);
      wave_add(1'b1, 4);
      wave_add(1'b0, 10);
    end
    wave_add(1'b1, 3);
    build_exp();
    play();
    compare_obs("glitch");
    chk("glitch_n", obs_q.size(), FILT_ON ? 2 : 4);
    if (obs_q.size() > 0) chk("glitch_on_time0", obs_q[0].h, FILT_ON ? 10 : 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
